// File: rtl/modport_stream_buffer.sv
// Two-entry skid buffer with occupancy/beat-count view tap; 1-cycle latency in->out.
// Backpressure: in_ready is registered from occupancy only, never from out_ready.
module modport_stream_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    output logic                   in_block,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   out_ready,
    output logic                   out_block,
    output logic [1:0]             view_count,
    output logic [COUNT_WIDTH-1:0] view_beats
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  m_q, m_d;
    logic [DATA_WIDTH-1:0]  s_q, s_d;
    logic [COUNT_WIDTH-1:0] beats_q, beats_d;
    logic                   in_ready_q, in_ready_d;
    logic                   in_block_q, in_block_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_block_q, out_block_d;
    logic                   push;
    logic                   pop;

    // Handshakes only look at registered flags, so no in->out combinational path.
    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        beats_d = beats_q;
        if (push) begin
            beats_d = beats_q + COUNT_WIDTH'(1);
        end
        case (state_q)
            EMPTY: begin
                if (push) begin
                    m_d     = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    m_d = in_data;
                end else if (push) begin
                    s_d     = in_data;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    m_d     = s_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flags are precomputed from the next state so every output comes straight from a flop.
        in_ready_d  = (state_d != FULL);
        in_block_d  = (state_d == FULL);
        out_valid_d = (state_d != EMPTY);
        out_block_d = (state_d == EMPTY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            m_q         <= '0;
            s_q         <= '0;
            beats_q     <= '0;
            in_ready_q  <= 1'b1;
            in_block_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_block_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            beats_q     <= beats_d;
            in_ready_q  <= in_ready_d;
            in_block_q  <= in_block_d;
            out_valid_q <= out_valid_d;
            out_block_q <= out_block_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign in_block   = in_block_q;
    assign out_valid  = out_valid_q;
    assign out_block  = out_block_q;
    assign out_data   = m_q;
    assign view_count = state_q;
    assign view_beats = beats_q;

endmodule

// File: tb/tb_modport_stream_buffer.sv
// Directed and random-stall bench for the two-entry stream buffer plus a narrow-counter wrap instance.
module tb_modport_stream_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        in_block;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        out_block;
    logic [1:0]  view_count;
    logic [15:0] view_beats;

    logic        w_in_valid;
    logic [31:0] w_in_data;
    logic        w_in_ready;
    logic        w_in_block;
    logic        w_out_valid;
    logic [31:0] w_out_data;
    logic        w_out_ready;
    logic        w_out_block;
    logic [1:0]  w_view_count;
    logic [3:0]  w_view_beats;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    modport_stream_buffer #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .in_block(in_block),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_block(out_block),
        .view_count(view_count), .view_beats(view_beats)
    );

    modport_stream_buffer #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_data(w_in_data), .in_ready(w_in_ready), .in_block(w_in_block),
        .out_valid(w_out_valid), .out_data(w_out_data), .out_ready(w_out_ready), .out_block(w_out_block),
        .view_count(w_view_count), .view_beats(w_view_beats)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),   64'd1);
        check({tag, "_in_block"},  64'(in_block),   64'd0);
        check({tag, "_out_valid"}, 64'(out_valid),  64'd0);
        check({tag, "_out_block"}, 64'(out_block),  64'd1);
        check({tag, "_out_data"},  64'(out_data),   64'd0);
        check({tag, "_count"},     64'(view_count), 64'd0);
        check({tag, "_beats"},     64'(view_beats), 64'd0);
    endtask

    logic [31:0] q[$];
    logic [31:0] held;
    logic [31:0] exp_d;
    logic        hold_chk;
    logic        push;
    logic        pop;
    int          sent;
    int          rcvd;
    int          cycles;

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_data     = 'x;
        out_ready   = 1'b0;
        w_in_valid  = 1'b0;
        w_in_data   = 'x;
        w_out_ready = 1'b1;

        // Reset then idle, with X on in_data while in_valid is low.
        tick();
        tick();
        check_idle("rst_held");
        rst = 1'b1;
        tick();
        tick();
        check_idle("rst_idle");

        // Single beat with consumer always ready.
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0001;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
        check("single_valid", 64'(out_valid),  64'd1);
        check("single_data",  64'(out_data),   64'hA5A5_0001);
        check("single_count", 64'(view_count), 64'd1);
        check("single_beats", 64'(view_beats), 64'd1);
        tick();
        check("single_empty_valid", 64'(out_valid), 64'd0);
        check("single_empty_block", 64'(out_block), 64'd1);

        // Fill with consumer stalled; the third beat must be held off.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        tick();
        check("fill1_count", 64'(view_count), 64'd1);
        in_data = 32'h22;
        tick();
        check("fill2_in_ready", 64'(in_ready),   64'd0);
        check("fill2_in_block", 64'(in_block),   64'd1);
        check("fill2_count",    64'(view_count), 64'd2);
        in_data = 32'h33;
        tick();
        tick();
        check("fill3_count", 64'(view_count), 64'd2);
        check("fill3_data",  64'(out_data),   64'h11);
        check("fill3_beats", 64'(view_beats), 64'd3);

        // Drain: 0x11 is on the output now, then 0x22 and 0x33 back to back.
        out_ready = 1'b1;
        tick();
        check("drain1_valid",    64'(out_valid), 64'd1);
        check("drain1_data",     64'(out_data),  64'h22);
        check("drain1_in_ready", 64'(in_ready),  64'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
        check("drain2_valid", 64'(out_valid),  64'd1);
        check("drain2_data",  64'(out_data),   64'h33);
        check("drain2_beats", 64'(view_beats), 64'd4);
        tick();
        check("drain3_empty", 64'(out_block),  64'd1);
        check("drain3_count", 64'(view_count), 64'd0);

        // Random producer/consumer stalls against a queue model.
        sent     = 0;
        rcvd     = 0;
        cycles   = 0;
        hold_chk = 1'b0;
        held     = '0;
        while (rcvd < 1000 && cycles < 20000) begin
            if (hold_chk) begin
                check("rand_stall_valid", 64'(out_valid), 64'd1);
                check("rand_stall_data",  64'(out_data),  64'(held));
            end
            if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 1) == 1);
            push = in_valid && in_ready;
            pop  = out_valid && out_ready;
            if (pop) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 32'hDEAD_DEAD;
                check("rand_order", 64'(out_data), 64'(exp_d));
                rcvd++;
            end
            if (push) begin
                q.push_back(in_data);
                sent++;
            end
            hold_chk = out_valid && !out_ready;
            held     = out_data;
            tick();
            cycles++;
            if (push) begin
                in_valid = 1'b0;
                in_data  = 'x;
            end
        end
        check("rand_complete", 64'(rcvd), 64'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        check("rand_end_count", 64'(view_count), 64'd0);
        check("rand_end_beats", 64'(view_beats), 64'd1004);

        // 4-bit counter wraps after 16 beats.
        w_in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            w_in_data = 32'h100 + i;
            tick();
            if (i == 15) check("wrap16_beats", 64'(w_view_beats), 64'd0);
        end
        w_in_valid = 1'b0;
        w_in_data  = 'x;
        check("wrap17_beats", 64'(w_view_beats), 64'd1);
        check("wrap17_data",  64'(w_out_data),   64'h110);

        // Async reset mid-stream with two beats held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hBEEF_0001;
        tick();
        in_data = 32'hBEEF_0002;
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
        check("pre_arst_count", 64'(view_count), 64'd2);
        #2;
        rst = 1'b0;
        #1;
        check_idle("arst");
        check("arst_wrap_beats", 64'(w_view_beats), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        check_idle("arst_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
